// File: rtl/hazard_pkg.sv
// Shared types and constants for the Execute-stage hazard scoreboard.
package hazard_pkg;

    // Architectural register index width.
    localparam int REG_ADDR_W = 5;

    // Fields of the instruction injected into EX as a bubble (sethi 0, %g0).
    localparam logic [1:0] OP_BR     = 2'b00;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    // One tracked in-flight instruction: what it will write once it retires.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  wr_dbl;
        logic                  icc_wr;
        logic                  y_wr;
    } hz_slot_t;

    // Full 32-bit encoding of the bubble instruction: op=00, rd=0, op2=100, imm22=0.
    function automatic logic [31:0] nop_insn();
        return {OP_BR, 5'd0, OP2_SETHI, 22'd0};
    endfunction

endpackage

// File: rtl/ex_hazard_scoreboard_if.sv
// Decode/Memory-facing signal bundle of the hazard scoreboard.
interface ex_hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic                  id_valid_in;
    logic [REG_ADDR_W-1:0] id_rs1_in;
    logic                  id_rs1_use_in;
    logic [REG_ADDR_W-1:0] id_rs2_in;
    logic                  id_rs2_use_in;
    logic [REG_ADDR_W-1:0] id_rd_in;
    logic                  id_rd_use_in;
    logic                  id_rd_dbl_use_in;
    logic                  id_regWrite_in;
    logic                  id_regWriteDouble_in;
    logic                  id_icc_use_in;
    logic                  id_icc_write_in;
    logic                  id_y_use_in;
    logic                  id_y_write_in;
    logic                  mem_ready;
    logic                  ex_annul_in;
    logic                  stall_out;
    logic                  bubble_out;
    logic [CNT_W-1:0]      stall_cycles_out;

    // Pipeline side: presents the Decode instruction and pipeline status.
    modport master (
        output id_valid_in, id_rs1_in, id_rs1_use_in, id_rs2_in, id_rs2_use_in,
               id_rd_in, id_rd_use_in, id_rd_dbl_use_in, id_regWrite_in,
               id_regWriteDouble_in, id_icc_use_in, id_icc_write_in,
               id_y_use_in, id_y_write_in, mem_ready, ex_annul_in,
        input  stall_out, bubble_out, stall_cycles_out
    );

    // Scoreboard side.
    modport slave (
        input  id_valid_in, id_rs1_in, id_rs1_use_in, id_rs2_in, id_rs2_use_in,
               id_rd_in, id_rd_use_in, id_rd_dbl_use_in, id_regWrite_in,
               id_regWriteDouble_in, id_icc_use_in, id_icc_write_in,
               id_y_use_in, id_y_write_in, mem_ready, ex_annul_in,
        output stall_out, bubble_out, stall_cycles_out
    );

endinterface

// File: rtl/hz_src_match.sv
// Compares one Decode register source against one in-flight slot.
module hz_src_match
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  use_i,
    input  logic                  dbl_src_i,
    input  hz_slot_t              slot_i,
    output logic                  hit_o
);

    // %g0 never creates a dependency; a double writer covers the even/odd pair.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] s, input hz_slot_t sl);
        logic same_reg;
        logic same_pair;
        same_reg  = (s == sl.rd);
        same_pair = sl.wr_dbl && (s[REG_ADDR_W-1:1] == sl.rd[REG_ADDR_W-1:1]);
        return sl.valid && sl.wr && (sl.rd != '0) && (s != '0) && (same_reg || same_pair);
    endfunction

    logic [REG_ADDR_W-1:0] src_odd;

    // A double source also reads the odd register of its pair.
    always_comb begin
        src_odd = {src_i[REG_ADDR_W-1:1], 1'b1};
        hit_o   = use_i && (reg_hit(src_i, slot_i) || (dbl_src_i && reg_hit(src_odd, slot_i)));
    end

endmodule

// File: rtl/ex_hazard_scoreboard.sv
// Execute-stage interlock: tracks writers in EX/MEM/WB and stalls Decode on
// true dependencies. No forwarding, so a consumer waits until its producer retires.
module ex_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
) (
    input logic                   clk,
    input logic                   reset,
    ex_hazard_scoreboard_if.slave bus
);

    hz_slot_t [DEPTH-1:0] slot_q;
    hz_slot_t [DEPTH-1:0] slot_d;
    logic     [CNT_W-1:0] stall_cnt_q;
    logic     [CNT_W-1:0] stall_cnt_d;

    logic [DEPTH-1:0] rs1_hit;
    logic [DEPTH-1:0] rs2_hit;
    logic [DEPTH-1:0] rd_hit;
    logic [DEPTH-1:0] icc_hit;
    logic [DEPTH-1:0] y_hit;

    logic     hazard;
    logic     bubble;
    logic     issue;
    hz_slot_t id_entry;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        hz_src_match u_rs1 (
            .src_i     (bus.id_rs1_in),
            .use_i     (bus.id_rs1_use_in),
            .dbl_src_i (1'b0),
            .slot_i    (slot_q[k]),
            .hit_o     (rs1_hit[k])
        );

        hz_src_match u_rs2 (
            .src_i     (bus.id_rs2_in),
            .use_i     (bus.id_rs2_use_in),
            .dbl_src_i (1'b0),
            .slot_i    (slot_q[k]),
            .hit_o     (rs2_hit[k])
        );

        // Store data: rd is read by st, and the rd pair by std.
        hz_src_match u_rd (
            .src_i     (bus.id_rd_in),
            .use_i     (bus.id_rd_use_in | bus.id_rd_dbl_use_in),
            .dbl_src_i (bus.id_rd_dbl_use_in),
            .slot_i    (slot_q[k]),
            .hit_o     (rd_hit[k])
        );

        assign icc_hit[k] = bus.id_icc_use_in & slot_q[k].valid & slot_q[k].icc_wr;
        assign y_hit[k]   = bus.id_y_use_in & slot_q[k].valid & slot_q[k].y_wr;
    end

    // Hazard detection and the slot image of the Decode instruction.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        id_entry        = '0;
        id_entry.valid  = 1'b1;
        id_entry.rd     = bus.id_rd_in;
        id_entry.wr     = bus.id_regWrite_in | bus.id_regWriteDouble_in;
        id_entry.wr_dbl = bus.id_regWriteDouble_in;
        id_entry.icc_wr = bus.id_icc_write_in;
        id_entry.y_wr   = bus.id_y_write_in;

        // An annulled instruction is killed, so it can neither stall nor issue.
        hazard = bus.id_valid_in && !bus.ex_annul_in &&
                 (|{rs1_hit, rs2_hit, rd_hit, icc_hit, y_hit});
        bubble = hazard && bus.mem_ready;
        issue  = bus.mem_ready && bus.id_valid_in && !bus.ex_annul_in && !hazard;
    end

    assign bus.stall_out        = hazard | ~bus.mem_ready;
    assign bus.bubble_out       = bubble;
    assign bus.stall_cycles_out = stall_cnt_q;

    // Slot shift: advance only when Memory accepts; EX gets the issue or a bubble.
    always_comb begin
        slot_d = slot_q;
        if (bus.mem_ready) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0] = issue ? id_entry : '0;
        end
    end

    // Saturating count of cycles in which a hazard bubble was injected.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers.
    // NOTE: non-blocking assignments here so every flop samples the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the slot array is reset because stale valid bits would fake hazards.
            slot_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_scoreboard.sv
// Self-checking bench for ex_hazard_scoreboard: directed vector table,
// hand-written reset sequence, then random stimulus against a set-based model.
module tb_ex_hazard_scoreboard;

    logic clk;
    logic reset;

    ex_hazard_scoreboard_if bus ();

    ex_hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_u;
        logic [4:0] rs2;
        logic       rs2_u;
        logic [4:0] rd;
        logic       rd_u;
        logic       rd_dbl;
        logic       rw;
        logic       rwd;
        logic       icc_u;
        logic       icc_w;
        logic       y_u;
        logic       y_w;
        logic       mr;
        logic       an;
        logic       exp_stall;
        logic       exp_bubble;
    } vec_t;

    // In-flight producer as the model sees it: the set of registers it writes.
    typedef struct {
        logic [31:0] wmask;
        bit          icc;
        bit          y;
        int          age;
    } flight_t;

    int total = 0;
    int bad   = 0;

    vec_t    tbl[$];
    flight_t fl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string n, input logic es, input logic eb);
        vec_t v;
        v = '{name: n, valid: 1'b0, rs1: 5'd0, rs1_u: 1'b0, rs2: 5'd0, rs2_u: 1'b0,
              rd: 5'd0, rd_u: 1'b0, rd_dbl: 1'b0, rw: 1'b0, rwd: 1'b0, icc_u: 1'b0,
              icc_w: 1'b0, y_u: 1'b0, y_w: 1'b0, mr: 1'b1, an: 1'b0,
              exp_stall: es, exp_bubble: eb};
        return v;
    endfunction

    function automatic vec_t wr_v(input string n, input logic [4:0] r, input logic es, input logic eb);
        vec_t v;
        v = mk(n, es, eb);
        v.valid = 1'b1;
        v.rd    = r;
        v.rw    = 1'b1;
        return v;
    endfunction

    function automatic vec_t rd_v(input string n, input logic [4:0] r, input logic es, input logic eb);
        vec_t v;
        v = mk(n, es, eb);
        v.valid = 1'b1;
        v.rs1   = r;
        v.rs1_u = 1'b1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_valid_in          = v.valid;
        bus.id_rs1_in            = v.rs1;
        bus.id_rs1_use_in        = v.rs1_u;
        bus.id_rs2_in            = v.rs2;
        bus.id_rs2_use_in        = v.rs2_u;
        bus.id_rd_in             = v.rd;
        bus.id_rd_use_in         = v.rd_u;
        bus.id_rd_dbl_use_in     = v.rd_dbl;
        bus.id_regWrite_in       = v.rw;
        bus.id_regWriteDouble_in = v.rwd;
        bus.id_icc_use_in        = v.icc_u;
        bus.id_icc_write_in      = v.icc_w;
        bus.id_y_use_in          = v.y_u;
        bus.id_y_write_in        = v.y_w;
        bus.mem_ready            = v.mr;
        bus.ex_annul_in          = v.an;
    endtask

    // ---------------- reference model (register sets) ----------------
    function automatic logic [31:0] read_set(input vec_t v);
        logic [31:0] m;
        m = '0;
        if (v.rs1_u) m[v.rs1] = 1'b1;
        if (v.rs2_u) m[v.rs2] = 1'b1;
        if (v.rd_u || v.rd_dbl) m[v.rd] = 1'b1;
        if (v.rd_dbl) m[v.rd | 5'd1] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] write_set(input vec_t v);
        logic [31:0] m;
        m = '0;
        if ((v.rw || v.rwd) && v.rd != 5'd0) begin
            if (v.rwd) begin
                m[v.rd & 5'b11110] = 1'b1;
                m[v.rd | 5'b00001] = 1'b1;
            end else begin
                m[v.rd] = 1'b1;
            end
        end
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bit model_hazard(input vec_t v);
        bit h;
        h = 1'b0;
        if (v.valid && !v.an) begin
            foreach (fl[i]) begin
                if ((read_set(v) & fl[i].wmask) != '0) h = 1'b1;
                if (v.icc_u && fl[i].icc) h = 1'b1;
                if (v.y_u && fl[i].y) h = 1'b1;
            end
        end
        return h;
    endfunction

    // Every producer lives for three pipeline advances after it issues.
    task automatic model_clock(input vec_t v, input bit haz);
        flight_t nq[$];
        flight_t e;
        if (v.mr) begin
            foreach (fl[i]) begin
                e = fl[i];
                e.age++;
                if (e.age < 3) nq.push_back(e);
            end
            if (v.valid && !v.an && !haz) begin
                e = '{wmask: write_set(v), icc: v.icc_w, y: v.y_w, age: 0};
                nq.push_back(e);
            end
            fl = nq;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(mk("idle", 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        fl.delete();
    endtask

    initial begin
        vec_t v;
        int   exp_cnt;
        bit   haz;
        bit   hold;

        // ---------------- directed vector table ----------------
        // Dependent add: three bubbles, then issue.
        tbl.push_back(wr_v("t2_add_r3", 5'd3, 1'b0, 1'b0));
        tbl.push_back(rd_v("t2_rd_r3_c1", 5'd3, 1'b1, 1'b1));
        tbl.push_back(rd_v("t2_rd_r3_c2", 5'd3, 1'b1, 1'b1));
        tbl.push_back(rd_v("t2_rd_r3_c3", 5'd3, 1'b1, 1'b1));
        tbl.push_back(rd_v("t2_rd_r3_c4", 5'd3, 1'b0, 1'b0));
        // %g0 and non-writing instructions never block.
        tbl.push_back(wr_v("t3_wr_r0", 5'd0, 1'b0, 1'b0));
        tbl.push_back(rd_v("t3_rd_r0", 5'd0, 1'b0, 1'b0));
        v = mk("t3_nowr_r5", 1'b0, 1'b0); v.valid = 1'b1; v.rd = 5'd5; tbl.push_back(v);
        tbl.push_back(rd_v("t3_rd_r5", 5'd5, 1'b0, 1'b0));
        // ldd r4 blocks a reader of r5.
        v = wr_v("t4_ldd_r4", 5'd4, 1'b0, 1'b0); v.rw = 1'b0; v.rwd = 1'b1; tbl.push_back(v);
        tbl.push_back(rd_v("t4_rd_r5_a", 5'd5, 1'b1, 1'b1));
        tbl.push_back(rd_v("t4_rd_r5_b", 5'd5, 1'b1, 1'b1));
        tbl.push_back(rd_v("t4_rd_r5_c", 5'd5, 1'b1, 1'b1));
        tbl.push_back(rd_v("t4_rd_r5_go", 5'd5, 1'b0, 1'b0));
        // std r6 reads the pair r6/r7.
        tbl.push_back(wr_v("t4_wr_r7", 5'd7, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            v = mk($sformatf("t4_std_r6_%0d", i), (i < 3), (i < 3));
            v.valid = 1'b1; v.rd = 5'd6; v.rd_dbl = 1'b1;
            tbl.push_back(v);
        end
        // icc dependency subcc -> bne.
        v = wr_v("t6_subcc", 5'd1, 1'b0, 1'b0); v.icc_w = 1'b1; tbl.push_back(v);
        for (int i = 0; i < 4; i++) begin
            v = mk($sformatf("t6_bne_%0d", i), (i < 3), (i < 3));
            v.valid = 1'b1; v.icc_u = 1'b1;
            tbl.push_back(v);
        end
        // Annulled delay slot writing r7 must not block a later reader.
        v = wr_v("t6_dslot_r7_annul", 5'd7, 1'b0, 1'b0); v.an = 1'b1; tbl.push_back(v);
        tbl.push_back(rd_v("t6_rd_r7", 5'd7, 1'b0, 1'b0));
        // Annul masks a real hazard for that one cycle (rs2 path).
        tbl.push_back(wr_v("an_wr_r9", 5'd9, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            v = mk($sformatf("an_rs2_r9_%0d", i), (i == 1 || i == 2), (i == 1 || i == 2));
            v.valid = 1'b1; v.rs2 = 5'd9; v.rs2_u = 1'b1; v.an = (i == 0);
            tbl.push_back(v);
        end
        // Y dependency.
        v = mk("y_wr", 1'b0, 1'b0); v.valid = 1'b1; v.y_w = 1'b1; tbl.push_back(v);
        for (int i = 0; i < 4; i++) begin
            v = mk($sformatf("y_rd_%0d", i), (i < 3), (i < 3));
            v.valid = 1'b1; v.y_u = 1'b1;
            tbl.push_back(v);
        end
        // Backpressure during a pending hazard freezes the slots.
        tbl.push_back(wr_v("t5_wr_r11", 5'd11, 1'b0, 1'b0));
        tbl.push_back(rd_v("t5_rd_adv", 5'd11, 1'b1, 1'b1));
        v = rd_v("t5_rd_frz0", 5'd11, 1'b1, 1'b0); v.mr = 1'b0; tbl.push_back(v);
        v = rd_v("t5_rd_frz1", 5'd11, 1'b1, 1'b0); v.mr = 1'b0; tbl.push_back(v);
        tbl.push_back(rd_v("t5_rd_adv1", 5'd11, 1'b1, 1'b1));
        tbl.push_back(rd_v("t5_rd_adv2", 5'd11, 1'b1, 1'b1));
        tbl.push_back(rd_v("t5_rd_go", 5'd11, 1'b0, 1'b0));
        v = mk("idle_mr0", 1'b1, 1'b0); v.mr = 1'b0; tbl.push_back(v);
        tbl.push_back(mk("idle", 1'b0, 1'b0));

        do_reset();
        exp_cnt = 0;
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            check({tbl[i].name, "_stall"}, 32'(bus.stall_out), 32'(tbl[i].exp_stall));
            check({tbl[i].name, "_bubble"}, 32'(bus.bubble_out), 32'(tbl[i].exp_bubble));
            check({tbl[i].name, "_cnt"}, bus.stall_cycles_out, 32'(exp_cnt));
            if (tbl[i].exp_bubble) exp_cnt++;
            @(posedge clk);
            #1;
        end

        // ---------------- reset in the middle of a stall ----------------
        do_reset();
        apply(wr_v("r_wr_r3", 5'd3, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        apply(rd_v("r_rd_r3", 5'd3, 1'b1, 1'b1));
        @(negedge clk);
        check("r_pre_stall", 32'(bus.stall_out), 32'd1);
        @(posedge clk);
        #2;
        check("r_mem_stall", 32'(bus.stall_out), 32'd1);
        reset = 1'b1;
        #1;
        check("r_async_stall", 32'(bus.stall_out), 32'd0);
        check("r_async_bubble", 32'(bus.bubble_out), 32'd0);
        check("r_async_cnt", bus.stall_cycles_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("r_after_stall", 32'(bus.stall_out), 32'd0);
        check("r_after_bubble", 32'(bus.bubble_out), 32'd0);
        check("r_after_cnt", bus.stall_cycles_out, 32'd0);

        // ---------------- random stimulus against the model ----------------
        do_reset();
        exp_cnt = 0;
        hold    = 1'b0;
        v       = mk("rnd", 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                v.valid  = ($urandom_range(0, 7) != 0);
                v.rs1    = 5'($urandom_range(0, 7));
                v.rs1_u  = 1'($urandom_range(0, 1));
                v.rs2    = 5'($urandom_range(0, 7));
                v.rs2_u  = ($urandom_range(0, 2) == 0);
                v.rd     = 5'($urandom_range(0, 7));
                v.rd_u   = ($urandom_range(0, 4) == 0);
                v.rd_dbl = ($urandom_range(0, 6) == 0);
                v.rw     = 1'($urandom_range(0, 1));
                v.rwd    = ($urandom_range(0, 6) == 0);
                v.icc_u  = ($urandom_range(0, 5) == 0);
                v.icc_w  = ($urandom_range(0, 4) == 0);
                v.y_u    = ($urandom_range(0, 9) == 0);
                v.y_w    = ($urandom_range(0, 9) == 0);
            end
            v.mr = ($urandom_range(0, 4) != 0);
            v.an = ($urandom_range(0, 9) == 0);
            apply(v);
            haz = model_hazard(v);
            @(negedge clk);
            check("rnd_stall", 32'(bus.stall_out), 32'(haz || !v.mr));
            check("rnd_bubble", 32'(bus.bubble_out), 32'(haz && v.mr));
            check("rnd_cnt", bus.stall_cycles_out, 32'(exp_cnt));
            if (haz && v.mr) exp_cnt++;
            @(posedge clk);
            #1;
            model_clock(v, haz);
            hold = haz && ($urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
